// File: rtl/dmem_sram_ctrl.sv
// Data-memory controller: one RISC-V load/store at a time onto a single port
// of a 32-bit byte-masked SRAM, with fixed two-edge response latency.
module dmem_sram_ctrl #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_csb,
   output logic              sram_web,
   output logic              sram_oeb,
   output logic [3:0]        sram_bytemask,
   output logic [31:0]       sram_i,
   input  logic [31:0]       sram_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e      state_q, state_d;
   logic        live_q, live_d;
   logic        err_q, err_d;
   logic        load_q, load_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;

   logic        accept;
   logic        req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_fmt;

   always_comb begin
      req_err = 1'b0;
      if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) req_err = 1'b1;
      if (req_we && req_funct3[2])                          req_err = 1'b1;
      if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
      if (|req_addr[31:ADDR_W+2])                           req_err = 1'b1;
   end

   // live_q holds req_ready low until the first edge after reset release.
   assign req_ready  = live_q && (state_q == IDLE || (state_q == RESP && resp_ready));
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = rerr_q;

   always_comb begin
      sram_csb      = 1'b1;
      sram_web      = 1'b1;
      sram_oeb      = 1'b1;
      sram_bytemask = '0;
      sram_a        = '0;
      sram_i        = '0;
      if (accept && !req_err) begin
         sram_csb = 1'b0;
         sram_a   = req_addr[ADDR_W+1:2];
         if (req_we) begin
            sram_web = 1'b0;
            case (req_funct3[1:0])
               2'b00: begin
                  sram_bytemask = 4'b0001 << req_addr[1:0];
                  sram_i        = {4{req_wdata[7:0]}};
               end
               2'b01: begin
                  sram_bytemask = 4'b0011 << req_addr[1:0];
                  sram_i        = {2{req_wdata[15:0]}};
               end
               default: begin
                  sram_bytemask = 4'b1111;
                  sram_i        = req_wdata;
               end
            endcase
         end else begin
            sram_oeb = 1'b0;
         end
      end
      if (state_q == ACCESS && load_q) sram_oeb = 1'b0;
   end

   always_comb begin
      byte_sel = sram_o[8*lane_q +: 8];
      half_sel = lane_q[1] ? sram_o[31:16] : sram_o[15:0];
      case (funct3_q)
         3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_fmt = {24'h0, byte_sel};
         3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_fmt = {16'h0, half_sel};
         default: load_fmt = sram_o;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      live_d   = 1'b1;
      err_d    = err_q;
      load_d   = load_q;
      funct3_d = funct3_q;
      lane_d   = lane_q;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS: begin
            state_d = RESP;
            rerr_d  = err_q;
            rdata_d = load_q ? load_fmt : '0;
         end
         RESP: begin
            if (accept)          state_d = ACCESS;
            else if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         err_d    = req_err;
         load_d   = !req_err && !req_we;
         funct3_d = req_funct3;
         lane_d   = req_addr[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         live_q   <= 1'b0;
         err_q    <= 1'b0;
         load_q   <= 1'b0;
         funct3_q <= '0;
         lane_q   <= '0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         live_q   <= live_d;
         err_q    <= err_d;
         load_q   <= load_d;
         funct3_q <= funct3_d;
         lane_q   <= lane_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
      end
   end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Self-checking bench for dmem_sram_ctrl: behavioural SRAM plus a byte-array
// reference memory; directed vectors followed by randomized traffic.
module tb_dmem_sram_ctrl;

   localparam int unsigned AW     = 6;
   localparam int unsigned NWORDS = 1 << AW;
   localparam int unsigned NBYTES = 4 * NWORDS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = '0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] sram_a;
   logic          sram_csb, sram_web, sram_oeb;
   logic [3:0]    sram_bytemask;
   logic [31:0]   sram_i;
   logic [31:0]   sram_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   dmem_sram_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .sram_a(sram_a), .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
      .sram_bytemask(sram_bytemask), .sram_i(sram_i), .sram_o(sram_o)
   );

   function automatic logic [31:0] init_word(int unsigned w);
      return (w * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // Masked SRAM macro: writes and read-latching on the clock edge; output
   // pins carry garbage whenever output enable is deasserted.
   logic [31:0] sram_mem [NWORDS];
   logic [31:0] sram_dout = '0;
   assign sram_o = sram_oeb ? 32'hBADBAD00 : sram_dout;

   initial begin
      for (int w = 0; w < NWORDS; w++) sram_mem[w] = init_word(w);
      forever begin
         @(posedge clk);
         if (!sram_csb) begin
            if (!sram_web) begin
               for (int b = 0; b < 4; b++)
                  if (sram_bytemask[b]) sram_mem[sram_a][8*b +: 8] <= sram_i[8*b +: 8];
            end else begin
               sram_dout <= sram_mem[sram_a];
            end
         end
      end
   end

   logic [7:0]  ref_mem [NBYTES];
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic ref_err(logic we, logic [2:0] f3, logic [31:0] addr);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (we && (f3 == 3'd4 || f3 == 3'd5))      return 1'b1;
      if (f3[1:0] == 2'd1 && addr % 2 != 0)      return 1'b1;
      if (f3[1:0] == 2'd2 && addr % 4 != 0)      return 1'b1;
      if (addr >= NBYTES)                        return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr);
      int unsigned n;
      logic [31:0] v;
      n = 1 << f3[1:0];
      v = '0;
      for (int k = 0; k < n; k++) v |= 32'(ref_mem[addr + k]) << (8 * k);
      if (f3 < 3'd4 && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
      return v;
   endfunction

   // Drives one request (optionally while handshaking a pending response),
   // checks the SRAM pins on the accept cycle and the ACCESS cycle.
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic rr);
      logic        legal, st, ld;
      int unsigned n;
      logic [3:0]  emask;
      logic [31:0] ei;
      legal = !ref_err(we, f3, addr);
      st    = legal && we;
      ld    = legal && !we;
      n     = 1 << f3[1:0];
      emask = '0;
      ei    = '0;
      if (st) begin
         for (int k = 0; k < n; k++) emask[(addr % 4) + k] = 1'b1;
         for (int k = 0; k < 4; k++) ei[8*k +: 8] = wd[8*(k % n) +: 8];
      end
      exp_err   = !legal;
      exp_rdata = ld ? ref_load(f3, addr) : 32'h0;
      if (st) for (int k = 0; k < n; k++) ref_mem[addr + k] = wd[8*k +: 8];

      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = rr;
      #1;
      check("req_ready", 32'(req_ready), 32'd1);
      check("acc_csb", 32'(sram_csb), 32'(!legal));
      check("acc_web", 32'(sram_web), 32'(!st));
      check("acc_oeb", 32'(sram_oeb), 32'(!ld));
      check("acc_a", 32'(sram_a), legal ? (addr >> 2) : 32'h0);
      check("acc_mask", 32'(sram_bytemask), 32'(emask));
      check("acc_i", sram_i, ei);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      check("access_valid", 32'(resp_valid), 32'd0);
      check("access_oeb", 32'(sram_oeb), 32'(!ld));
      check("access_csb", 32'(sram_csb), 32'd1);
   endtask

   task automatic get_resp(input int unsigned hold, input logic release_it);
      @(posedge clk);
      #1;
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_err", 32'(resp_err), 32'(exp_err));
      last_rdata = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, exp_rdata);
         check("hold_err", 32'(resp_err), 32'(exp_err));
         check("hold_ready", 32'(req_ready), 32'd0);
      end
      if (release_it) begin
         @(negedge clk);
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         check("released", 32'(resp_valid), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_rdata"}, resp_rdata, 32'd0);
      check({tag, "_err"}, 32'(resp_err), 32'd0);
      check({tag, "_csb"}, 32'(sram_csb), 32'd1);
      check({tag, "_web"}, 32'(sram_web), 32'd1);
      check({tag, "_oeb"}, 32'(sram_oeb), 32'd1);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
   endtask

   initial begin
      logic        pend;
      logic        we, rel;
      logic [2:0]  f3;
      logic [31:0] addr;

      for (int w = 0; w < NWORDS; w++)
         for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8 * b);

      #3;
      check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", 32'(req_ready), 32'd1);
      check("idle_csb", 32'(sram_csb), 32'd1);
      check("idle_mask", 32'(sram_bytemask), 32'd0);

      // Directed word/byte/half traffic around word 2.
      send(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1'b0); get_resp(0, 1'b1);
      send(1'b0, 3'b000, 32'hB, 32'h0, 1'b0); get_resp(0, 1'b1);
      check("lb_const", last_rdata, 32'hFFFFFFDE);
      send(1'b0, 3'b100, 32'hB, 32'h0, 1'b0); get_resp(0, 1'b1);
      check("lbu_const", last_rdata, 32'h000000DE);
      send(1'b0, 3'b001, 32'hA, 32'h0, 1'b0); get_resp(0, 1'b1);
      check("lh_const", last_rdata, 32'hFFFFDEAD);
      send(1'b0, 3'b101, 32'hA, 32'h0, 1'b0); get_resp(0, 1'b1);
      check("lhu_const", last_rdata, 32'h0000DEAD);
      send(1'b1, 3'b000, 32'h9, 32'h12345655, 1'b0); get_resp(0, 1'b1);
      send(1'b0, 3'b010, 32'h8, 32'h0, 1'b0); get_resp(0, 1'b1);
      check("lw_const", last_rdata, 32'hDEAD55EF);

      // Error cases never touch the SRAM.
      send(1'b0, 3'b001, 32'h9, 32'h0, 1'b0); get_resp(0, 1'b1);
      send(1'b0, 3'b010, 32'h102, 32'h0, 1'b0); get_resp(0, 1'b1);
      send(1'b1, 3'b100, 32'h4, 32'hFFFFFFFF, 1'b0); get_resp(0, 1'b1);
      send(1'b0, 3'b011, 32'h0, 32'h0, 1'b0); get_resp(0, 1'b1);

      // Backpressure then back-to-back accept on the handshake edge.
      send(1'b0, 3'b010, 32'h8, 32'h0, 1'b0); get_resp(3, 1'b0);
      send(1'b0, 3'b100, 32'hB, 32'h0, 1'b1); get_resp(0, 1'b1);

      // Reset in the middle of an access drops it.
      send(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("no_resp_after_rst", 32'(resp_valid), 32'd0);
      end
      send(1'b0, 3'b010, 32'h8, 32'h0, 1'b0); get_resp(0, 1'b1);

      pend = 1'b0;
      for (int i = 0; i < 300; i++) begin
         we   = $urandom_range(0, 1);
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom_range(0, NBYTES - 1);
         if ($urandom_range(0, 9) == 0) addr |= 32'h1 << $urandom_range(AW + 2, 31);
         send(we, f3, addr, $urandom, pend);
         rel = ($urandom_range(0, 2) != 0);
         get_resp($urandom_range(0, 2), rel);
         pend = !rel;
      end
      if (pend) begin
         @(negedge clk);
         resp_ready = 1'b1;
         @(posedge clk);
         #1;
         resp_ready = 1'b0;
         check("final_release", 32'(resp_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
